// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and default width for the repeated-subtraction divider
package div_pkg;
    localparam int DEF_WIDTH = 16;
    typedef enum logic [2:0] {S_IDLE, S_LD_A, S_LD_B, S_CMP, S_SUB, S_DONE} state_t;
endpackage

// File: rtl/div_repsub_if.sv
// div_repsub_if: operand bus and result signals of the divider
interface div_repsub_if import div_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             done;
    logic             div_by_zero;
    modport master (output start, data_in, input quotient, remainder, done, div_by_zero);
    modport slave (input start, data_in, output quotient, remainder, done, div_by_zero);
endinterface

// File: rtl/div_datapath.sv
// div_datapath: R/B/Q registers with subtractor, comparator and status flags
module div_datapath import div_pkg::*; #(parameter int WIDTH = DEF_WIDTH) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ld_a,
    input  logic             ld_b,
    input  logic             clr_q,
    input  logic             sub,
    input  logic             inc_q,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] q,
    output logic             eqz,
    output logic             lt
);
    logic [WIDTH-1:0] b;

    assign eqz = b == '0;
    assign lt  = r < b;

    // load operands, then shrink R by B while counting subtractions in Q
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r <= '0;
            b <= '0;
            q <= '0;
        end else begin
            r <= ld_a ? data_in : sub ? r - b : r;
            b <= ld_b ? data_in : b;
            q <= clr_q ? '0 : inc_q ? q + WIDTH'(1) : q;
        end
    end
endmodule

// File: rtl/div_repsub.sv
// div_repsub: unsigned divider by repeated subtraction with a shared operand bus
module div_repsub import div_pkg::*; #(parameter int WIDTH = DEF_WIDTH) (
    input logic        clk,
    input logic        rst_n,
    div_repsub_if.slave bus
);
    state_t           state;
    logic             done;
    logic             div_by_zero;
    logic             eqz;
    logic             lt;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;

    div_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk    (clk),
        .rst_n  (rst_n),
        .data_in(bus.data_in),
        .ld_a   (state == S_LD_A),
        .ld_b   (state == S_LD_B),
        .clr_q  (state == S_LD_B),
        .sub    (state == S_SUB),
        .inc_q  (state == S_SUB),
        .r      (r),
        .q      (q),
        .eqz    (eqz),
        .lt     (lt)
    );

    assign bus.quotient    = q;
    assign bus.remainder   = r;
    assign bus.done        = done;
    assign bus.div_by_zero = div_by_zero;

    // controller: sequence operand loads, compare/subtract loop, and hold results until start drops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: state <= bus.start ? S_LD_A : S_IDLE;
                S_LD_A: state <= S_LD_B;
                S_LD_B: begin
                    div_by_zero <= 1'b0;
                    state       <= S_CMP;
                end
                S_CMP: begin
                    div_by_zero <= eqz;
                    done        <= eqz || lt;
                    state       <= (eqz || lt) ? S_DONE : S_SUB;
                end
                S_SUB: state <= S_CMP;
                S_DONE: begin
                    done  <= bus.start;
                    state <= bus.start ? S_DONE : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_repsub.sv
// tb_div_repsub: randomized and directed checks of div_repsub against an arithmetic model
module tb_div_repsub;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    int last_lat = 0;
    logic exp_valid = 1'b0;
    logic [W-1:0] exp_q, exp_r;
    logic exp_z;

    div_repsub_if #(.WIDTH(W)) bus ();
    div_repsub_if #(.WIDTH(8)) sbus ();

    div_repsub #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    div_repsub #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(sbus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void model(input int a, input int b, output int q, output int r,
                                  output bit z, output int lat);
        if (b == 0) begin
            q = 0; r = a; z = 1'b1; lat = 3;
        end else begin
            q = a / b; r = a % b; z = 1'b0; lat = 3 + 2 * q;
        end
    endfunction

    always @(negedge clk) begin
        if (exp_valid && bus.done) begin
            chk("quotient", 32'(bus.quotient), 32'(exp_q));
            chk("remainder", 32'(bus.remainder), 32'(exp_r));
            chk("div_by_zero", 32'(bus.div_by_zero), 32'(exp_z));
        end
    end

    task automatic run(input int a, input int b, input int hold, input int abort_at);
        int q, r, lat, n;
        bit z, seen;
        model(a, b, q, r, z, lat);
        @(negedge clk);
        exp_valid = 1'b0;
        bus.start = 1'b1;
        bus.data_in = W'($urandom);
        @(posedge clk);
        n = 0;
        seen = 1'b0;
        while (!seen && n < lat + 10) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.data_in = n == 0 ? W'(a) : n == 1 ? W'(b) : W'($urandom);
            if (n == 2) begin
                exp_q = W'(q); exp_r = W'(r); exp_z = z; exp_valid = 1'b1;
            end
            if (abort_at > 0 && n == abort_at - 1) begin
                exp_valid = 1'b0;
                rst_n = 1'b0;
                @(posedge clk);
                @(negedge clk);
                chk("abort_quotient", 32'(bus.quotient), 0);
                chk("abort_remainder", 32'(bus.remainder), 0);
                chk("abort_done", 32'(bus.done), 0);
                chk("abort_dbz", 32'(bus.div_by_zero), 0);
                rst_n = 1'b1;
                return;
            end
            if (bus.done) seen = 1'b1;
            else begin
                @(posedge clk);
                n++;
            end
        end
        last_lat = seen ? n : -1;
        chk("latency", last_lat, lat);
        bus.start = hold > 0;
        repeat (hold) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_done", 32'(bus.done), 1);
        end
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("idle_done", 32'(bus.done), 0);
    endtask

    initial begin
        int n, q, d, r, a;
        bit seen;
        bus.start = 1'b0;
        bus.data_in = '0;
        sbus.start = 1'b0;
        sbus.data_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_quotient", 32'(bus.quotient), 0);
        chk("rst_remainder", 32'(bus.remainder), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_dbz", 32'(bus.div_by_zero), 0);
        chk("rst8_done", 32'(sbus.done), 0);
        rst_n = 1'b1;

        run(17, 5, 0, 0);
        chk("lit17_5_q", 32'(bus.quotient), 3);
        chk("lit17_5_r", 32'(bus.remainder), 2);
        chk("lit17_5_lat", last_lat, 9);
        run(5, 17, 0, 0);
        chk("lit5_17_q", 32'(bus.quotient), 0);
        chk("lit5_17_r", 32'(bus.remainder), 5);
        chk("lit5_17_lat", last_lat, 3);
        run(20, 4, 3, 0);
        chk("lit20_4_q", 32'(bus.quotient), 5);
        chk("lit20_4_r", 32'(bus.remainder), 0);
        chk("lit20_4_lat", last_lat, 13);
        run(100, 0, 0, 0);
        chk("lit100_0_q", 32'(bus.quotient), 0);
        chk("lit100_0_r", 32'(bus.remainder), 100);
        chk("lit100_0_dbz", 32'(bus.div_by_zero), 1);
        chk("lit100_0_lat", last_lat, 3);
        run(0, 7, 0, 0);
        chk("lit0_7_q", 32'(bus.quotient), 0);
        chk("lit0_7_r", 32'(bus.remainder), 0);
        chk("lit0_7_lat", last_lat, 3);
        run(1000, 3, 0, 20);
        run(9, 2, 0, 0);
        chk("lit9_2_q", 32'(bus.quotient), 4);
        chk("lit9_2_r", 32'(bus.remainder), 1);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) run(int'($urandom_range(0, 65535)), 0, $urandom_range(0, 2), 0);
            else begin
                q = $urandom_range(0, 200);
                d = $urandom_range(1, 300);
                r = $urandom_range(0, d - 1);
                a = q * d + r;
                run(a, d, $urandom_range(0, 2), 0);
            end
        end

        @(negedge clk);
        sbus.start = 1'b1;
        @(posedge clk);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 600) begin
            @(negedge clk);
            sbus.start = 1'b0;
            sbus.data_in = n == 0 ? 8'd255 : n == 1 ? 8'd1 : 8'($urandom);
            if (sbus.done) seen = 1'b1;
            else begin
                @(posedge clk);
                n++;
            end
        end
        chk("w8_latency", seen ? n : -1, 513);
        chk("w8_quotient", 32'(sbus.quotient), 255);
        chk("w8_remainder", 32'(sbus.remainder), 0);
        chk("w8_dbz", 32'(sbus.div_by_zero), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/div_repsub.md
DIV_REPSUB -- requirements
Module: div_repsub

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request a division; sampled in S_IDLE only.
REQ-005 data_in  input  WIDTH  shared operand bus: dividend one cycle, then divisor the next.
REQ-006 quotient  output  WIDTH  result quotient, registered.
REQ-007 remainder  output  WIDTH  result remainder, registered.
REQ-008 done  output  1  high while in S_DONE; results valid whenever done=1.
REQ-009 div_by_zero  output  1  high with done when the captured divisor was 0.

Function
REQ-010 The block SHALL divide unsigned operands by repeated subtraction, mirroring the team's repeated-addition multiplier.
REQ-011 FSM states SHALL be S_IDLE, S_LD_A, S_LD_B, S_CMP, S_SUB, S_DONE.
REQ-012 S_IDLE: start=1 -> S_LD_A; else stay.
REQ-013 S_LD_A: R <= data_in (dividend); -> S_LD_B.
REQ-014 S_LD_B: B <= data_in (divisor), Q <= 0, div_by_zero <= 0; -> S_CMP.
REQ-015 S_CMP: B==0 -> div_by_zero <= 1, -> S_DONE; R<B -> S_DONE; else -> S_SUB.
REQ-016 S_SUB: R <= R-B, Q <= Q+1; -> S_CMP.
REQ-017 S_DONE: done=1; start=0 -> S_IDLE; start=1 -> stay (no auto-restart).
REQ-018 Latency: with start high at edge E0, done SHALL rise after edge E(3+2q), q = final quotient; div-by-zero -> after E3.
REQ-019 quotient=Q and remainder=R continuously; values SHALL hold from S_DONE until the next S_LD_A/S_LD_B load.
REQ-020 Comparison R<B SHALL be unsigned full-width; Q cannot overflow because q <= dividend <= 2^WIDTH-1.
REQ-021 On divide-by-zero, quotient SHALL read 0 and remainder SHALL read the dividend.
REQ-022 Dividend 0 with nonzero divisor SHALL give q=0, r=0, done after E3.
REQ-023 data_in SHALL be ignored in all states other than S_LD_A and S_LD_B.

Reset
REQ-024 rst_n=0 at a rising edge SHALL force S_IDLE, R=0, B=0, Q=0, done=0, div_by_zero=0.
REQ-025 Reset asserted mid-operation (any state) SHALL abort the division with no partial result retained.
REQ-026 After release, the first start is accepted at the first edge with rst_n=1 and start=1.

Structure
REQ-027 State encodings and default WIDTH SHALL live in shared package div_pkg.
REQ-028 Datapath (R, B, Q registers, subtractor, comparator, eqz/lt flags) SHALL be sub-module div_datapath; controller FSM in div_repsub drives ldA, ldB, clrQ, sub, incQ.
REQ-029 No combinational path SHALL exist from data_in to any output.

Verification
REQ-030 17 then 5 on data_in, start=1 -> quotient=3, remainder=2, done after E9, div_by_zero=0.
REQ-031 5 then 17 -> quotient=0, remainder=5, done after E3.
REQ-032 20 then 4 -> quotient=5, remainder=0, done after E13.
REQ-033 100 then 0 -> done after E3, div_by_zero=1, quotient=0, remainder=100.
REQ-034 65535 then 1 -> quotient=65535, remainder=0, done after E131073; no wrap of Q.
REQ-035 Start 1000/3, pull rst_n low at E20 -> all outputs 0 next edge; new 9/2 run -> quotient=4, remainder=1.
